// File: rtl/wb_stage.sv
// Writeback stage: aligns load data, writes the 32-entry register file,
// serves the two ID-stage read ports with write-through bypass, and
// exposes the current and previous-cycle writeback for EX forwarding.
module wb_stage #(
  parameter bit RF_CLR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_wb,
  input  logic [2:0]  ld_code_wb,
  input  logic [4:0]  rd_adr_wb,
  input  logic [31:0] rd_data_wb,
  input  logic        wbk_rd_reg_wb,
  input  logic [31:0] ld_data_wb,
  input  logic        rst_pipe_wb,
  input  logic [4:0]  rs1_adr_id,
  input  logic [4:0]  rs2_adr_id,
  output logic [31:0] rs1_data_id,
  output logic [31:0] rs2_data_id,
  output logic        wbk_en_fw,
  output logic [4:0]  wbk_adr_fw,
  output logic [31:0] wbk_data_fw,
  output logic        wbk_en_dly,
  output logic [4:0]  wbk_adr_dly,
  output logic [31:0] wbk_data_dly
);

  // Pick the addressed byte/half from the raw word and extend it.
  function automatic logic [31:0] align_load(input logic [2:0]  code,
                                             input logic [1:0]  ofs,
                                             input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (ofs)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'd0;
    endcase
    half_v = ofs[1] ? word[31:16] : word[15:0];
    case (code)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = word;
      3'b100:  res_v = {24'd0, byte_v};
      3'b101:  res_v = {16'd0, half_v};
      default: res_v = 32'd0;
    endcase
    return res_v;
  endfunction

  logic [31:0] rf_q [0:31];
  logic        we_s;
  logic [31:0] wd_s;
  logic        wbk_en_q;
  logic [4:0]  wbk_adr_q;
  logic [31:0] wbk_data_q;

  // Write data/enable for this cycle; a flush or x0 target kills the write.
  always_comb begin
    wd_s = rd_data_wb;
    if (cmd_ld_wb) begin
      wd_s = align_load(ld_code_wb, rd_data_wb[1:0], ld_data_wb);
    end else begin
      wd_s = rd_data_wb;
    end
    we_s = wbk_rd_reg_wb & ~rst_pipe_wb & (rd_adr_wb != 5'd0);
  end

  generate
    if (RF_CLR) begin : g_rf_clr
      // Register file with asynchronous clear of every entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'd0;
          end
        end else if (we_s) begin
          rf_q[rd_adr_wb] <= wd_s;
        end
      end
    end else begin : g_rf_noclr
      // Register file without reset; x0 is masked on the read side.
      always_ff @(posedge clk) begin
        if (we_s) begin
          rf_q[rd_adr_wb] <= wd_s;
        end
      end
    end
  endgenerate

  // Read port 1: x0 is hard zero, same-cycle write bypasses the array.
  always_comb begin
    rs1_data_id = 32'd0;
    if (rs1_adr_id == 5'd0) begin
      rs1_data_id = 32'd0;
    end else if (we_s && (rs1_adr_id == rd_adr_wb)) begin
      rs1_data_id = wd_s;
    end else begin
      rs1_data_id = rf_q[rs1_adr_id];
    end
  end

  // Read port 2: identical structure to port 1.
  always_comb begin
    rs2_data_id = 32'd0;
    if (rs2_adr_id == 5'd0) begin
      rs2_data_id = 32'd0;
    end else if (we_s && (rs2_adr_id == rd_adr_wb)) begin
      rs2_data_id = wd_s;
    end else begin
      rs2_data_id = rf_q[rs2_adr_id];
    end
  end

  assign wbk_en_fw   = we_s;
  assign wbk_adr_fw  = rd_adr_wb;
  assign wbk_data_fw = wd_s;

  // Delayed writeback copy, captured every cycle without stall gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbk_en_q   <= 1'b0;
      wbk_adr_q  <= 5'd0;
      wbk_data_q <= 32'd0;
    end else begin
      wbk_en_q   <= we_s;
      wbk_adr_q  <= rd_adr_wb;
      wbk_data_q <= wd_s;
    end
  end

  assign wbk_en_dly   = wbk_en_q;
  assign wbk_adr_dly  = wbk_adr_q;
  assign wbk_data_dly = wbk_data_q;

endmodule
